// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter and related blocks.
//   - Arbiter FSM state type.
//   - Requester count and fixed requester slot assignments.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ   = 4;

  localparam int unsigned REQ_CPU   = 0;
  localparam int unsigned REQ_DMA   = 1;
  localparam int unsigned REQ_GFX   = 2;
  localparam int unsigned REQ_AUDIO = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/memory_bus_arbiter_rr_priority_picker.sv
// Round-robin priority picker (combinational).
// It scans the request vector starting at last_i+1 and wraps modulo NUM_REQ.
//   req_i  : per-requester request flags
//   last_i : index granted most recently; this index has the lowest priority
//   idx_o  : selected requester (equals last_i when nothing is requested)
//   any_o  : at least one request is present
module rr_priority_picker
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [1:0]         idx_o,
  output logic               any_o
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    idx_o = last_i;
    any_o = |req_i;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last_i + 2'(k);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter that shares one synchronous SRAM/BRAM port among four
// valid/ready requesters. Each grant is limited to MAX_BURST accepted beats.
// A single IDLE arbitration cycle separates consecutive grants.
//   CLK, RSTb            : clock, asynchronous active-low reset
//   req_valid/req_wr     : per-requester request and write flag
//   req_addr/req_wdata   : flattened per-requester address / write data
//   req_ready            : one-hot ready to the granted requester
//   req_rdata/req_rvalid : broadcast read data and a one-hot valid pulse
//   mem_*                : memory port (read data arrives one cycle after mem_en)
//   grant_idx            : current or last granted requester
module memory_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                          CLK,
  input  logic                          RSTb,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_BITS-1:0]          req_rdata,
  output logic [NUM_REQ-1:0]            req_rvalid,
  output logic [ADDR_BITS-1:0]          mem_addr,
  output logic [DATA_BITS-1:0]          mem_wdata,
  output logic                          mem_en,
  output logic                          mem_wr,
  input  logic [DATA_BITS-1:0]          mem_rdata,
  output logic [1:0]                    grant_idx
);

  localparam int unsigned   BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_q,  last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic [1:0] pick;
  logic       any_req;

  rr_priority_picker u_picker (
    .req_i  (req_valid),
    .last_i (last_q),
    .idx_o  (pick),
    .any_o  (any_req)
  );

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= 2'd3;
      burst_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    burst_d   = burst_q;
    rvalid_d  = '0;
    req_ready = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    // The address and data mux always follows grant_q. In IDLE the values are
    // don't-care because mem_en is low.
    mem_addr  = req_addr[grant_q*ADDR_BITS +: ADDR_BITS];
    mem_wdata = req_wdata[grant_q*DATA_BITS +: DATA_BITS];

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          burst_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready[grant_q] = 1'b1;
        mem_en             = req_valid[grant_q];
        mem_wr             = req_valid[grant_q] & req_wr[grant_q];
        if (req_valid[grant_q]) begin
          rvalid_d[grant_q] = ~req_wr[grant_q];
          burst_d           = burst_q + 1'b1;
          if (burst_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end else begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_rdata  = mem_rdata;
  assign req_rvalid = rvalid_q;
  assign grant_idx  = grant_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter. It drives a MAX_BURST=8
// instance with a memory model and a scoreboard of expected read returns.
// A second instance with MAX_BURST=1 covers single-beat grants.
module tb_memory_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        load_mem;

  logic [3:0]  req_valid, req_wr, req_ready, req_rvalid;
  logic [63:0] req_addr, req_wdata;
  logic [15:0] req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr;
  logic [1:0]  grant_idx;

  logic [3:0]  rv1, wr1, ready1, rvalid1;
  logic [63:0] addr1, wdata1;
  logic [15:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        mem_en1, mem_wr1;
  logic [1:0]  grant1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] data;
  } sb_t;
  sb_t         sb_q[$];
  sb_t         mon_e;
  logic [15:0] ref_w [logic [15:0]];
  logic [15:0] mem [0:65535];
  logic [15:0] mon_a;

  always #5 CLK = ~CLK;

  memory_bus_arbiter #(.ADDR_BITS(16), .DATA_BITS(16), .MAX_BURST(8)) dut (
    .CLK(CLK), .RSTb(RSTb), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .req_rdata(req_rdata), .req_rvalid(req_rvalid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .grant_idx(grant_idx)
  );

  memory_bus_arbiter #(.ADDR_BITS(16), .DATA_BITS(16), .MAX_BURST(1)) dut1 (
    .CLK(CLK), .RSTb(RSTb), .req_valid(rv1), .req_wr(wr1),
    .req_addr(addr1), .req_wdata(wdata1), .req_ready(ready1),
    .req_rdata(rdata1), .req_rvalid(rvalid1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_en(mem_en1), .mem_wr(mem_wr1),
    .mem_rdata(mem_rdata1), .grant_idx(grant1)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] exp_val(input logic [15:0] a);
    if (ref_w.exists(a)) return ref_w[a];
    return init_val(a);
  endfunction

  // Synchronous memory with one-cycle read latency.
  always @(posedge CLK) begin
    if (load_mem) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
    end else if (mem_en) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  always @(posedge CLK) begin
    if (mem_en1 && !mem_wr1) mem_rdata1 <= mem_addr1 ^ 16'hA5A5;
  end

  // Scoreboard: accepted reads push the expected return; rvalid pops it.
  always @(negedge CLK) begin
    if (RSTb && !load_mem) begin
      if (req_rvalid !== 4'b0000) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_rvalid got rvalid=%b exp none pending", req_rvalid);
        end else begin
          mon_e = sb_q.pop_front();
          if (req_rvalid !== 4'(1 << mon_e.idx) || req_rdata !== mon_e.data) begin
            errors++;
            $display("FAIL sb_read got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                     req_rvalid, req_rdata, 4'(1 << mon_e.idx), mon_e.data);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_a = req_addr[i*16 +: 16];
          if (req_wr[i]) begin
            ref_w[mon_a] = req_wdata[i*16 +: 16];
          end else begin
            mon_e.idx  = 2'(i);
            mon_e.data = exp_val(mon_a);
            sb_q.push_back(mon_e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    req_valid = '0;
    req_wr    = '0;
    rv1       = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem got en=%b wr=%b exp 0 0", mem_en, mem_wr); end
    checks++; if (req_rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid got %b exp 0000", req_rvalid); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", grant_idx); end
    checks++; if (ready1 !== 4'b0000) begin errors++; $display("FAIL rst_ready1 got %b exp 0000", ready1); end
    load_mem = 1'b0;
    RSTb     = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    tick();
    req_addr[15:0] = 16'h0010;
    req_wr[0]      = 1'b0;
    req_valid      = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL sr_c0_ready got %b exp 0000", req_ready); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sr_c1_ready got %b exp 0001", req_ready); end
    checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL sr_c1_mem got en=%b wr=%b addr=%h exp 1 0 0010", mem_en, mem_wr, mem_addr); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (req_rvalid !== 4'b0001 || req_rdata !== 16'h1234) begin
      errors++; $display("FAIL sr_c2_data got rvalid=%b rdata=%h exp 0001 1234", req_rvalid, req_rdata); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0000 || req_rvalid !== 4'b0000) begin
      errors++; $display("FAIL sr_c3_idle got ready=%b rvalid=%b exp 0000 0000", req_ready, req_rvalid); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL sr_grant got %0d exp 0", grant_idx); end
    settle();
  endtask

  task automatic test_simultaneous();
    RSTb = 1'b0; #1; RSTb = 1'b1;
    tick();
    req_addr[15:0]  = 16'h0020;
    req_addr[47:32] = 16'h0030;
    req_valid       = 4'b0101;
    tick(); #1;
    checks++; if (req_ready !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++; $display("FAIL sim_first got ready=%b grant=%0d exp 0001 0", req_ready, grant_idx); end
    tick();
    req_addr[15:0] = 16'h0021;
    tick();
    req_valid[0] = 1'b0;
    tick(); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL sim_idle_gap got %b exp 0000", req_ready); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0100 || grant_idx !== 2'd2) begin
      errors++; $display("FAIL sim_second got ready=%b grant=%0d exp 0100 2", req_ready, grant_idx); end
    tick();
    settle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    int unsigned m, g;
    RSTb = 1'b0; #1; RSTb = 1'b1;
    for (int unsigned k = 0; k <= 44; k++) begin
      tick();
      req_valid = 4'b1111;
      req_wr    = 4'b0000;
      for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = 16'($urandom_range(0, 255));
      #1;
      exp_r = 4'b0000;
      g     = 0;
      if (k != 0) begin
        m = (k - 1) % 9;
        g = ((k - 1) / 9) % 4;
        if (m < 8) exp_r = 4'(1 << g);
      end
      checks++; if (req_ready !== exp_r) begin
        errors++; $display("FAIL rr_ready cycle %0d got %b exp %b", k, req_ready, exp_r); end
      if (exp_r != 4'b0000) begin
        checks++; if (grant_idx !== 2'(g)) begin
          errors++; $display("FAIL rr_grant cycle %0d got %0d exp %0d", k, grant_idx, g); end
      end
    end
    settle();
  endtask

  task automatic test_write_read();
    tick();
    req_valid        = 4'b0010;
    req_wr           = 4'b0010;
    req_addr[31:16]  = 16'h0100;
    req_wdata[31:16] = 16'hBEEF;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wr_c0_ready got %b exp 0000", req_ready); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0010 || mem_en !== 1'b1 || mem_wr !== 1'b1 ||
                  mem_addr !== 16'h0100 || mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL wr_beat got ready=%b en=%b wr=%b addr=%h wdata=%h exp 0010 1 1 0100 beef",
                         req_ready, mem_en, mem_wr, mem_addr, mem_wdata); end
    tick();
    req_wr = 4'b0000;
    #1;
    checks++; if (req_rvalid !== 4'b0000 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL wr_no_rvalid got rvalid=%b mem_wr=%b exp 0000 0", req_rvalid, mem_wr); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (req_rvalid !== 4'b0010 || req_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL wr_readback got rvalid=%b rdata=%h exp 0010 beef", req_rvalid, req_rdata); end
    settle();
  endtask

  task automatic test_reset_mid_burst();
    tick();
    req_valid       = 4'b0100;
    req_addr[47:32] = 16'h0040;
    tick(); req_addr[47:32] = 16'h0041;
    tick(); req_addr[47:32] = 16'h0042;
    tick(); #1;
    checks++; if (req_ready !== 4'b0100 || req_rvalid !== 4'b0100) begin
      errors++; $display("FAIL rm_pre got ready=%b rvalid=%b exp 0100 0100", req_ready, req_rvalid); end
    RSTb = 1'b0;
    #1;
    sb_q.delete();
    checks++; if (req_ready !== 4'b0000 || mem_en !== 1'b0 || req_rvalid !== 4'b0000) begin
      errors++; $display("FAIL rm_abort got ready=%b en=%b rvalid=%b exp 0000 0 0000", req_ready, mem_en, req_rvalid); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rm_grant_rst got %0d exp 0", grant_idx); end
    req_valid       = 4'b0110;
    req_addr[31:16] = 16'h0050;
    #1;
    RSTb = 1'b1;
    tick(); #1;
    checks++; if (req_ready !== 4'b0010 || grant_idx !== 2'd1) begin
      errors++; $display("FAIL rm_after got ready=%b grant=%0d exp 0010 1", req_ready, grant_idx); end
    tick();
    settle();
  endtask

  task automatic test_max_burst1();
    logic [15:0] exp_d;
    tick();
    rv1 = 4'b1000;
    wr1 = 4'b0000;
    for (int unsigned k = 0; k < 10; k++) begin
      addr1[63:48] = 16'h0030 + 16'(k);
      #1;
      checks++; if (ready1 !== ((k % 2 == 1) ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL mb1_ready cycle %0d got %b", k, ready1); end
      if (k >= 2 && k % 2 == 0) begin
        exp_d = (16'h0030 + 16'(k - 1)) ^ 16'hA5A5;
        checks++; if (rvalid1 !== 4'b1000 || rdata1 !== exp_d || grant1 !== 2'd3) begin
          errors++; $display("FAIL mb1_data cycle %0d got rvalid=%b rdata=%h grant=%0d exp 1000 %h 3",
                             k, rvalid1, rdata1, grant1, exp_d); end
      end else if (k % 2 == 1) begin
        checks++; if (rvalid1 !== 4'b0000) begin
          errors++; $display("FAIL mb1_norv cycle %0d got %b exp 0000", k, rvalid1); end
      end
      tick();
    end
    settle();
  endtask

  initial begin
    RSTb      = 1'b0;
    load_mem  = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    rv1       = '0; wr1    = '0; addr1    = '0; wdata1    = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_write_read();
    test_reset_mid_burst();
    test_max_burst1();
    checks++; if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d pending exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
